// File: rtl/ping_pong_ctrl.sv
// Ping-pong buffer controller: producer frames land in one bank while the
// consumer drains the other; the banks swap once the write bank is full and
// the read bank has been fully issued. The two-bank buffer itself is external.
module ping_pong_ctrl #(
  parameter int unsigned BIT_LENGTH = 64,
  parameter int unsigned DEPTH      = 16,
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  // producer side
  input  logic                  wr_valid,
  input  logic [BIT_LENGTH-1:0] wr_data,
  input  logic                  wr_last,
  output logic                  wr_ready,
  // consumer side
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic                  rd_last,
  // buffer port A (write)
  output logic                  ena,
  output logic                  wea,
  output logic [AW-1:0]         addra,
  output logic [BIT_LENGTH-1:0] dina,
  // buffer port B (read)
  output logic                  enb,
  output logic [AW-1:0]         addrb,
  // bank control and status
  output logic                  ping_pong,
  output logic                  swap,
  output logic [15:0]           frame_cnt
);

  logic [AW-1:0] wr_cnt;
  logic [AW-1:0] wr_len;
  logic          wr_full;
  logic [AW-1:0] rd_cnt;
  logic [AW-1:0] rd_len;
  logic          rd_avail;

  logic          wr_fire;
  logic          wr_close;
  logic          rd_issue;
  logic          rd_close;

  // Handshakes and buffer strobes; everything is gated off while rst is high.
  always_comb begin
    wr_ready = ~wr_full & ~rst;
    wr_fire  = wr_valid & wr_ready;
    wr_close = wr_fire & (wr_last | (wr_cnt == AW'(DEPTH - 1)));
    ena      = wr_fire;
    wea      = wr_fire;
    addra    = wr_cnt;
    dina     = wr_data;

    rd_issue = rd_avail & rd_ready & ~rst;
    rd_close = rd_issue & (rd_cnt == rd_len);
    enb      = rd_issue;
    addrb    = rd_cnt;

    // wr_full blocks writes and ~rd_avail blocks reads, so a swap cycle is idle.
    swap     = wr_full & ~rd_avail & ~rst;
  end

  // Write-side frame tracking: count words, close on wr_last or a full bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt  <= '0;
      wr_len  <= '0;
      wr_full <= 1'b0;
    end else if (swap) begin
      wr_full <= 1'b0;
    end else if (wr_close) begin
      wr_full <= 1'b1;
      wr_len  <= wr_cnt;
      wr_cnt  <= '0;
    end else if (wr_fire) begin
      wr_cnt  <= wr_cnt + AW'(1);
    end
  end

  // Read-side frame tracking: issue addresses 0..rd_len, then wait for a swap.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt   <= '0;
      rd_len   <= '0;
      rd_avail <= 1'b0;
    end else if (swap) begin
      rd_avail <= 1'b1;
      rd_len   <= wr_len;
    end else if (rd_close) begin
      rd_avail <= 1'b0;
      rd_cnt   <= '0;
    end else if (rd_issue) begin
      rd_cnt   <= rd_cnt + AW'(1);
    end
  end

  // Bank select and frame counter advance on every swap.
  always_ff @(posedge clk) begin
    if (rst) begin
      ping_pong <= 1'b0;
      frame_cnt <= '0;
    end else if (swap) begin
      ping_pong <= ~ping_pong;
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

  // Track the one-cycle buffer read latency for the consumer flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      rd_valid <= rd_issue;
      rd_last  <= rd_close;
    end
  end

endmodule

// File: tb/tb_ping_pong_ctrl.sv
// Bench for ping_pong_ctrl: behavioural two-bank buffer, queue scoreboard
// fed by the producer driver, monitor draining it on every rd_valid.
module tb_ping_pong_ctrl;

  localparam int unsigned BL    = 64;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic          clk;
  logic          rst;
  logic          wr_valid;
  logic [BL-1:0] wr_data;
  logic          wr_last;
  logic          wr_ready;
  logic          rd_ready;
  logic          rd_valid;
  logic          rd_last;
  logic          ena;
  logic          wea;
  logic [AW-1:0] addra;
  logic [BL-1:0] dina;
  logic          enb;
  logic [AW-1:0] addrb;
  logic          ping_pong;
  logic          swap;
  logic [15:0]   frame_cnt;

  ping_pong_ctrl #(.BIT_LENGTH(BL), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last), .wr_ready(wr_ready),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_last(rd_last),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .enb(enb), .addrb(addrb),
    .ping_pong(ping_pong), .swap(swap), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // External dual-bank buffer: write bank = ping_pong, read bank = ~ping_pong.
  logic [BL-1:0] mem0 [DEPTH];
  logic [BL-1:0] mem1 [DEPTH];
  logic [BL-1:0] doutb;
  always @(posedge clk) begin
    if (ena && wea) begin
      if (ping_pong) mem1[addra] <= dina;
      else           mem0[addra] <= dina;
    end
    if (enb) doutb <= ping_pong ? mem0[addrb] : mem1[addrb];
  end

  typedef struct packed {
    logic [BL-1:0] data;
    logic          last;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   rd_seen  = 0;
  int   fpos     = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [BL-1:0] mk(input int f, input int i);
    return 64'hC0DE_0000_0000_0000 | (64'(f) << 16) | 64'(i);
  endfunction

  // Monitor: every rd_valid pops one expected word.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && rd_valid) begin
        if (sbq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_empty: rd_valid with data %0h but nothing expected", doutb);
        end else begin
          e = sbq.pop_front();
          check("rd_data", 64'(doutb), 64'(e.data));
          check("rd_last", 64'(rd_last), 64'(e.last));
          rd_seen++;
        end
      end
    end
  endtask

  // Present one word and hold it until accepted; expected read entry is queued.
  task automatic put_word(input logic [BL-1:0] d, input logic last);
    logic acc;
    int   guard;
    wr_valid = 1'b1;
    wr_data  = d;
    wr_last  = last;
    acc      = 1'b0;
    guard    = 0;
    while (!acc && guard < 100) begin
      @(negedge clk);
      acc = wr_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL wr_timeout: word %0h not accepted, wr_ready %0b expected 1", d, wr_ready);
    end else begin
      sbq.push_back('{data: d, last: (last || fpos == int'(DEPTH) - 1)});
      fpos = (last || fpos == int'(DEPTH) - 1) ? 0 : fpos + 1;
    end
  endtask

  task automatic put_frame(input int f, input int n, input logic use_last);
    for (int i = 0; i < n; i++) put_word(mk(f, i), use_last && (i == n - 1));
  endtask

  // Run until the scoreboard is empty and no read is in flight.
  task automatic wait_drain();
    int guard;
    guard = 0;
    while (!(sbq.size() == 0 && !rd_valid && !enb) && guard < 300) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 300) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d words left, expected 0", sbq.size());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int base;
  int c0;
  int n;
  logic sw;

  initial begin
    fork
      monitor();
    join_none

    // Reset with both sides requesting: strobes must stay low.
    rst      = 1'b1;
    wr_valid = 1'b1;
    wr_data  = '0;
    wr_last  = 1'b0;
    rd_ready = 1'b1;
    @(negedge clk);
    check("rst_ena", 64'(ena), 64'(0));
    check("rst_wea", 64'(wea), 64'(0));
    check("rst_enb", 64'(enb), 64'(0));
    tick();
    @(negedge clk);
    check("rst_rd_valid", 64'(rd_valid), 64'(0));
    check("rst_swap", 64'(swap), 64'(0));
    tick();
    rst      = 1'b0;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    @(negedge clk);
    check("init_wr_ready", 64'(wr_ready), 64'(1));
    check("init_ping_pong", 64'(ping_pong), 64'(0));
    check("init_frame_cnt", 64'(frame_cnt), 64'(0));
    check("init_rd_valid", 64'(rd_valid), 64'(0));
    tick();

    // Full frame of 16 without wr_last closes on its own.
    put_frame(1, 16, 1'b0);
    wr_valid = 1'b0;
    @(negedge clk);
    check("full_swap_pulse", 64'(swap), 64'(1));
    check("full_wr_ready_low", 64'(wr_ready), 64'(0));
    check("full_pp_before", 64'(ping_pong), 64'(0));
    tick();
    @(negedge clk);
    check("full_swap_gone", 64'(swap), 64'(0));
    check("full_pp_after", 64'(ping_pong), 64'(1));
    check("full_frame_cnt", 64'(frame_cnt), 64'(1));
    check("full_wr_ready_back", 64'(wr_ready), 64'(1));
    tick();

    // Read it back from bank 0 while ping_pong = 1.
    base     = rd_seen;
    rd_ready = 1'b1;
    @(negedge clk);
    check("rd0_enb", 64'(enb), 64'(1));
    check("rd0_addrb", 64'(addrb), 64'(0));
    wait_drain();
    check("full_read_count", 64'(rd_seen - base), 64'(16));

    // Short frame ended by wr_last.
    rd_ready = 1'b0;
    put_frame(2, 5, 1'b1);
    wr_valid = 1'b0;
    @(negedge clk);
    check("short_swap_pulse", 64'(swap), 64'(1));
    tick();
    base     = rd_seen;
    rd_ready = 1'b1;
    wait_drain();
    check("short_read_count", 64'(rd_seen - base), 64'(5));
    check("short_frame_cnt", 64'(frame_cnt), 64'(2));

    // Second frame completes while the first is still unread.
    rd_ready = 1'b0;
    base     = rd_seen;
    put_frame(3, 16, 1'b0);
    put_frame(4, 16, 1'b0);
    wr_valid = 1'b1;
    wr_data  = mk(5, 0);
    wr_last  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_wr_ready", 64'(wr_ready), 64'(0));
      tick();
    end
    rd_ready = 1'b1;
    n  = 0;
    sw = 1'b0;
    while (!sw && n < 50) begin
      @(negedge clk);
      n++;
      sw = swap;
      tick();
    end
    check("stall_swap_after_last_issue", 64'(n), 64'(17));
    put_frame(5, 5, 1'b1);
    wr_valid = 1'b0;
    wait_drain();
    check("stall_read_count", 64'(rd_seen - base), 64'(37));
    check("stall_frame_cnt", 64'(frame_cnt), 64'(5));

    // Continuous streaming, 4 frames of 16: one swap cycle per frame.
    base = rd_seen;
    c0   = cyc;
    for (int f = 0; f < 4; f++) put_frame(10 + f, 16, 1'b0);
    check("stream_write_cycles", 64'(cyc - c0), 64'(67));
    wr_valid = 1'b0;
    wait_drain();
    check("stream_read_count", 64'(rd_seen - base), 64'(64));
    check("stream_frame_cnt", 64'(frame_cnt), 64'(9));

    // Reset mid-frame: 7 words written, 3 of the previous frame read.
    rd_ready = 1'b0;
    put_frame(20, 16, 1'b0);
    put_frame(21, 7, 1'b0);
    wr_valid = 1'b0;
    base     = rd_seen;
    rd_ready = 1'b1;
    repeat (3) tick();
    rd_ready = 1'b0;
    tick();
    check("pre_rst_reads", 64'(rd_seen - base), 64'(3));
    rst      = 1'b1;
    wr_valid = 1'b1;
    wr_data  = mk(99, 0);
    rd_ready = 1'b1;
    @(negedge clk);
    check("midrst_ena", 64'(ena), 64'(0));
    check("midrst_enb", 64'(enb), 64'(0));
    tick();
    rst      = 1'b0;
    wr_valid = 1'b0;
    sbq.delete();
    fpos = 0;
    @(negedge clk);
    check("post_rst_wr_ready", 64'(wr_ready), 64'(1));
    check("post_rst_ping_pong", 64'(ping_pong), 64'(0));
    check("post_rst_frame_cnt", 64'(frame_cnt), 64'(0));
    check("post_rst_enb", 64'(enb), 64'(0));
    check("post_rst_swap", 64'(swap), 64'(0));
    tick();
    rd_ready = 1'b0;
    base     = rd_seen;
    put_frame(30, 3, 1'b1);
    wr_valid = 1'b0;
    @(negedge clk);
    check("post_rst_swap_pulse", 64'(swap), 64'(1));
    check("post_rst_bank0", 64'(ping_pong), 64'(0));
    tick();
    rd_ready = 1'b1;
    wait_drain();
    check("post_rst_read_count", 64'(rd_seen - base), 64'(3));
    check("post_rst_frame_cnt1", 64'(frame_cnt), 64'(1));
    check("post_rst_pp1", 64'(ping_pong), 64'(1));

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
